// File: rtl/gpsdo_loop_sequencer.sv
// Supervisory sequencer for the GPSDO discipline loop: walks ACQ/TRACK/LOCK/HOLD on each
// per-PPS phase error and drives the PID enable, gain set, integrator clear, divider realign and LED.
module gpsdo_loop_sequencer #(
    parameter int unsigned PPS_TIMEOUT_CYC = 32'd12_000_000,
    parameter int unsigned TRACK_WIN       = 32'd100,
    parameter int unsigned LOCK_WIN        = 32'd8,
    parameter int unsigned UNLOCK_WIN      = 32'd50,
    parameter int unsigned LOCK_COUNT      = 32'd16,
    parameter int unsigned DIVRST_CYC      = 32'd4
) (
    input  logic               CLK_SYS,
    input  logic               CLK_RST,
    input  logic signed [24:0] Meas_Err,
    input  logic               Meas_Valid,
    output logic               Pid_En,
    output logic [1:0]         Pid_Gain_Sel,
    output logic               Pid_Int_Clr,
    output logic               Div_Rst,
    output logic               Led_Lock,
    output logic               Holdover,
    output logic [1:0]         State
);

    localparam int unsigned TO_W = $clog2(PPS_TIMEOUT_CYC + 32'd1);
    localparam int unsigned LC_W = $clog2(LOCK_COUNT + 32'd1);
    localparam int unsigned DR_W = $clog2(DIVRST_CYC + 32'd1);

    localparam logic [TO_W-1:0] TO_LIM      = TO_W'(PPS_TIMEOUT_CYC);
    localparam logic [LC_W-1:0] LC_LIM      = LC_W'(LOCK_COUNT);
    localparam logic [DR_W-1:0] DR_LOAD     = DR_W'(DIVRST_CYC);
    localparam logic [24:0]     TRACK_WIN_C = 25'(TRACK_WIN);
    localparam logic [24:0]     LOCK_WIN_C  = 25'(LOCK_WIN);
    localparam logic [24:0]     UNLOCK_WIN_C = 25'(UNLOCK_WIN);

    typedef enum logic [1:0] {
        ST_ACQ   = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOCK  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [TO_W-1:0] timeout_cnt_r;
    logic [TO_W-1:0] timeout_cnt_nxt_s;
    logic [LC_W-1:0] lock_cnt_r;
    logic [LC_W-1:0] lock_cnt_nxt_s;
    logic [LC_W-1:0] lock_inc_s;
    logic [DR_W-1:0] div_cnt_r;
    logic [DR_W-1:0] div_cnt_nxt_s;
    logic [24:0]     abs_err_s;
    logic            gt_track_s;
    logic            in_lock_s;
    logic            gt_unlock_s;
    logic            timeout_hit_s;
    logic            fire_s;
    logic            int_clr_nxt_s;
    logic            pid_en_nxt_s;
    logic [1:0]      gain_nxt_s;
    logic            pid_en_r;
    logic [1:0]      gain_r;
    logic            int_clr_r;
    logic            div_rst_r;
    logic            led_lock_r;
    logic            holdover_r;

    // Magnitude of the phase error; computed unsigned so -2^24 becomes 2^24 instead of wrapping.
    always_comb begin
        if (Meas_Err[24]) begin
            abs_err_s = $unsigned(~Meas_Err) + 25'd1;
        end else begin
            abs_err_s = $unsigned(Meas_Err);
        end
    end

    assign gt_track_s    = (abs_err_s > TRACK_WIN_C);
    assign in_lock_s     = (abs_err_s <= LOCK_WIN_C);
    assign gt_unlock_s   = (abs_err_s > UNLOCK_WIN_C);
    // Expiry is the cycle the counter would step onto the limit; a coincident valid wins.
    assign timeout_hit_s = !Meas_Valid && (timeout_cnt_r >= (TO_LIM - TO_W'(1)));
    assign lock_inc_s    = (lock_cnt_r < LC_LIM) ? (lock_cnt_r + LC_W'(1)) : LC_LIM;

    // PPS-loss counter: cleared by every measurement, saturating at the limit.
    always_comb begin
        if (Meas_Valid) begin
            timeout_cnt_nxt_s = {TO_W{1'b0}};
        end else if (timeout_cnt_r < TO_LIM) begin
            timeout_cnt_nxt_s = timeout_cnt_r + TO_W'(1);
        end else begin
            timeout_cnt_nxt_s = timeout_cnt_r;
        end
    end

    // Next-state, lock counter and event decisions.
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = lock_cnt_r;
        fire_s         = 1'b0;
        int_clr_nxt_s  = 1'b0;
        case (state_r)
            ST_ACQ: begin
                if (Meas_Valid) begin
                    if (gt_track_s) begin
                        fire_s = 1'b1;
                    end else begin
                        state_nxt_s    = ST_TRACK;
                        int_clr_nxt_s  = 1'b1;
                        lock_cnt_nxt_s = {LC_W{1'b0}};
                    end
                end else begin
                    state_nxt_s = ST_ACQ;
                end
            end
            ST_TRACK: begin
                if (Meas_Valid) begin
                    if (gt_track_s) begin
                        state_nxt_s    = ST_ACQ;
                        fire_s         = 1'b1;
                        lock_cnt_nxt_s = {LC_W{1'b0}};
                    end else if (in_lock_s) begin
                        lock_cnt_nxt_s = lock_inc_s;
                        if (lock_inc_s == LC_LIM) begin
                            state_nxt_s = ST_LOCK;
                        end else begin
                            state_nxt_s = ST_TRACK;
                        end
                    end else begin
                        lock_cnt_nxt_s = {LC_W{1'b0}};
                    end
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_TRACK;
                end
            end
            ST_LOCK: begin
                if (Meas_Valid) begin
                    if (gt_unlock_s) begin
                        state_nxt_s    = ST_TRACK;
                        lock_cnt_nxt_s = {LC_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_LOCK;
                    end
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_LOCK;
                end
            end
            ST_HOLD: begin
                if (Meas_Valid) begin
                    lock_cnt_nxt_s = {LC_W{1'b0}};
                    if (gt_track_s) begin
                        state_nxt_s = ST_ACQ;
                        fire_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_TRACK;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s    = ST_ACQ;
                lock_cnt_nxt_s = {LC_W{1'b0}};
            end
        endcase
    end

    // Divider realign width counter; a re-fire restarts the full width.
    always_comb begin
        if (fire_s) begin
            div_cnt_nxt_s = DR_LOAD;
        end else if (div_cnt_r != {DR_W{1'b0}}) begin
            div_cnt_nxt_s = div_cnt_r - DR_W'(1);
        end else begin
            div_cnt_nxt_s = {DR_W{1'b0}};
        end
    end

    // Output decode from the upcoming state; HOLD keeps whatever gain set was last applied.
    always_comb begin
        pid_en_nxt_s = (state_nxt_s == ST_TRACK) || (state_nxt_s == ST_LOCK);
        case (state_nxt_s)
            ST_ACQ:   gain_nxt_s = 2'd0;
            ST_TRACK: gain_nxt_s = 2'd1;
            ST_LOCK:  gain_nxt_s = 2'd2;
            ST_HOLD:  gain_nxt_s = gain_r;
            default:  gain_nxt_s = 2'd0;
        endcase
    end

    // State register.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            state_r <= ST_ACQ;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            timeout_cnt_r <= {TO_W{1'b0}};
            lock_cnt_r    <= {LC_W{1'b0}};
            div_cnt_r     <= {DR_W{1'b0}};
            pid_en_r      <= 1'b0;
            gain_r        <= 2'd0;
            int_clr_r     <= 1'b0;
            div_rst_r     <= 1'b0;
            led_lock_r    <= 1'b0;
            holdover_r    <= 1'b0;
        end else begin
            timeout_cnt_r <= timeout_cnt_nxt_s;
            lock_cnt_r    <= lock_cnt_nxt_s;
            div_cnt_r     <= div_cnt_nxt_s;
            pid_en_r      <= pid_en_nxt_s;
            gain_r        <= gain_nxt_s;
            int_clr_r     <= int_clr_nxt_s;
            div_rst_r     <= (div_cnt_nxt_s != {DR_W{1'b0}});
            led_lock_r    <= (state_nxt_s == ST_LOCK);
            holdover_r    <= (state_nxt_s == ST_HOLD);
        end
    end

    assign Pid_En       = pid_en_r;
    assign Pid_Gain_Sel = gain_r;
    assign Pid_Int_Clr  = int_clr_r;
    assign Div_Rst      = div_rst_r;
    assign Led_Lock     = led_lock_r;
    assign Holdover     = holdover_r;
    assign State        = state_r;

endmodule

// File: tb/tb_gpsdo_loop_sequencer.sv
// Bench for gpsdo_loop_sequencer: directed scenarios plus random PPS traffic, checked every
// cycle against an integer-level loop model.
module tb_gpsdo_loop_sequencer;

    localparam int TO  = 100;
    localparam int LC  = 4;
    localparam int TW  = 100;
    localparam int LW  = 8;
    localparam int UW  = 50;
    localparam int DRC = 4;

    logic               CLK_SYS = 1'b0;
    logic               CLK_RST;
    logic signed [24:0] Meas_Err = 25'sd0;
    logic               Meas_Valid = 1'b0;
    logic               Pid_En;
    logic [1:0]         Pid_Gain_Sel;
    logic               Pid_Int_Clr;
    logic               Div_Rst;
    logic               Led_Lock;
    logic               Holdover;
    logic [1:0]         State;

    int n_tests = 0;
    int n_fail  = 0;

    gpsdo_loop_sequencer #(
        .PPS_TIMEOUT_CYC(TO),
        .LOCK_COUNT     (LC)
    ) dut (
        .CLK_SYS     (CLK_SYS),
        .CLK_RST     (CLK_RST),
        .Meas_Err    (Meas_Err),
        .Meas_Valid  (Meas_Valid),
        .Pid_En      (Pid_En),
        .Pid_Gain_Sel(Pid_Gain_Sel),
        .Pid_Int_Clr (Pid_Int_Clr),
        .Div_Rst     (Div_Rst),
        .Led_Lock    (Led_Lock),
        .Holdover    (Holdover),
        .State       (State)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    // Loop model: mode 0..3 = ACQ/TRACK/LOCK/HOLD, plus plain integer bookkeeping.
    typedef struct packed {
        logic [1:0] mode;
        int         lock;
        int         since;
        int         div;
        logic       clr;
        logic [1:0] gain;
    } model_t;

    model_t m = '0;

    function automatic model_t model_next(model_t c, logic v, logic signed [24:0] e);
        model_t n;
        int     a;
        logic   fire;
        n     = c;
        fire  = 1'b0;
        n.clr = 1'b0;
        if (v) begin
            a = (e < 0) ? -int'(e) : int'(e);
            n.since = 0;
            case (c.mode)
                2'd0: begin
                    if (a <= TW) begin
                        n.mode = 2'd1; n.clr = 1'b1; n.lock = 0; n.gain = 2'd1;
                    end else begin
                        fire = 1'b1;
                    end
                end
                2'd1: begin
                    if (a > TW) begin
                        n.mode = 2'd0; fire = 1'b1; n.gain = 2'd0; n.lock = 0;
                    end else begin
                        n.lock = (a <= LW) ? ((c.lock < LC) ? c.lock + 1 : LC) : 0;
                        if (n.lock == LC) begin
                            n.mode = 2'd2; n.gain = 2'd2;
                        end
                    end
                end
                2'd2: begin
                    if (a > UW) begin
                        n.mode = 2'd1; n.lock = 0; n.gain = 2'd1;
                    end
                end
                default: begin
                    n.lock = 0;
                    if (a <= TW) begin
                        n.mode = 2'd1; n.gain = 2'd1;
                    end else begin
                        n.mode = 2'd0; n.gain = 2'd0; fire = 1'b1;
                    end
                end
            endcase
        end else begin
            n.since = (c.since < TO) ? c.since + 1 : TO;
            if (n.since == TO && c.since < TO && (c.mode == 2'd1 || c.mode == 2'd2)) begin
                n.mode = 2'd3;
            end
        end
        n.div = fire ? DRC : ((c.div > 0) ? c.div - 1 : 0);
        return n;
    endfunction

    function automatic logic [8:0] exp_out(model_t x);
        return {x.mode, (x.mode == 2'd1 || x.mode == 2'd2), x.gain, x.clr,
                (x.div > 0), (x.mode == 2'd2), (x.mode == 2'd3)};
    endfunction

    initial begin
        forever begin
            @(posedge CLK_SYS or negedge CLK_RST);
            if (!CLK_RST) m = '0;
            else m = model_next(m, Meas_Valid, Meas_Err);
        end
    end

    // Cycle compare of every output against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge CLK_SYS);
            n_tests++;
            if ({State, Pid_En, Pid_Gain_Sel, Pid_Int_Clr, Div_Rst, Led_Lock, Holdover} !== exp_out(m)) begin
                n_fail++;
                $display("FAIL cycle_compare t=%0t dut=%b model=%b", $time,
                         {State, Pid_En, Pid_Gain_Sel, Pid_Int_Clr, Div_Rst, Led_Lock, Holdover},
                         exp_out(m));
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic pps(input logic signed [24:0] e);
        Meas_Valid = 1'b1;
        Meas_Err   = e;
        @(negedge CLK_SYS);
        Meas_Valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK_SYS);
    endtask

    int cnt;
    int r;
    int errs3 [7] = '{3, -8, 5, 9, 2, 2, 2};

    initial begin
        CLK_RST = 1'b1;
        #1 CLK_RST = 1'b0;
        idle(3);
        chk("rst_state", int'(State), 0);
        chk("rst_outs", int'({Pid_En, Pid_Gain_Sel, Pid_Int_Clr, Div_Rst, Led_Lock, Holdover}), 0);
        CLK_RST = 1'b1;
        idle(1);

        // Large error in ACQ: realign pulse only.
        pps(25'sd500);
        chk("acq_stay", int'(State), 0);
        chk("acq_pid_off", int'(Pid_En), 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt += int'(Div_Rst);
            @(negedge CLK_SYS);
        end
        chk("divrst_width", cnt, 4);

        // Close the loop.
        pps(25'sd60);
        chk("track_state", int'(State), 1);
        chk("track_pid_en", int'(Pid_En), 1);
        chk("track_gain", int'(Pid_Gain_Sel), 1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cnt += int'(Pid_Int_Clr);
            @(negedge CLK_SYS);
        end
        chk("intclr_once", cnt, 1);

        // Lock run with a break at 9.
        for (int i = 0; i < 7; i++) pps(25'(errs3[i]));
        chk("no_lock_yet", int'(State), 1);
        pps(25'sd2);
        chk("lock_state", int'(State), 2);
        chk("lock_led", int'(Led_Lock), 1);
        chk("lock_gain", int'(Pid_Gain_Sel), 2);
        pps(25'sd50);
        chk("unlock_edge_stay", int'(State), 2);
        pps(-25'sd51);
        chk("unlock_state", int'(State), 1);
        chk("unlock_led", int'(Led_Lock), 0);
        repeat (4) pps(25'sd0);
        chk("relock", int'(State), 2);

        // PPS loss and recovery.
        idle(99);
        chk("pre_timeout", int'(State), 2);
        idle(1);
        chk("hold_state", int'(State), 3);
        chk("hold_flag", int'(Holdover), 1);
        chk("hold_pid_off", int'(Pid_En), 0);
        chk("hold_gain_kept", int'(Pid_Gain_Sel), 2);
        pps(25'sd20);
        chk("hold_to_track", int'(State), 1);
        chk("hold_no_intclr", int'(Pid_Int_Clr), 0);
        repeat (4) pps(25'sd0);
        idle(100);
        chk("hold_again", int'(State), 3);
        pps(-25'sd200);
        chk("hold_to_acq", int'(State), 0);
        chk("hold_to_acq_div", int'(Div_Rst), 1);

        // Valid on the exact expiry cycle, then the most negative error.
        idle(6);
        pps(25'sd0);
        idle(99);
        pps(25'sd3);
        chk("valid_wins_timeout", int'(State), 1);
        chk("valid_wins_hold", int'(Holdover), 0);
        idle(99);
        chk("timer_restarted", int'(State), 1);
        pps(25'h1000000);
        chk("min_err_acq", int'(State), 0);
        chk("min_err_div", int'(Div_Rst), 1);

        // Asynchronous reset mid-pulse and in LOCK.
        idle(6);
        pps(25'sd500);
        #2 CLK_RST = 1'b0;
        #1 chk("arst_div_outs", int'({State, Pid_En, Pid_Gain_Sel, Pid_Int_Clr, Div_Rst, Led_Lock, Holdover}), 0);
        @(negedge CLK_SYS);
        CLK_RST = 1'b1;
        idle(1);
        repeat (5) pps(25'sd0);
        chk("pre_arst_lock", int'(State), 2);
        #2 CLK_RST = 1'b0;
        #1 chk("arst_lock_outs", int'({State, Pid_En, Pid_Gain_Sel, Pid_Int_Clr, Div_Rst, Led_Lock, Holdover}), 0);
        @(negedge CLK_SYS);
        CLK_RST = 1'b1;
        idle(1);

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 25) idle(int'($urandom_range(1, 110)));
            else if (r < 70) pps(25'(int'($urandom_range(0, 20)) - 10));
            else if (r < 90) pps(25'(int'($urandom_range(0, 260)) - 130));
            else if (r < 95) pps(25'($urandom));
            else if (r < 98) pps(25'h1000000);
            else pps(25'h0FFFFFF);
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
